pe_6bus: RTL and testbench

Single-context processing element (PE) for the CGRA array. It has six 32-bit input buses: four mesh neighbours (up, down, left, right) and two bypass lanes. A static 22-bit configuration word selects two operands, an ALU operation and an internal holding-register action. The registered result is driven onto any subset of the six output buses, so each PE is one tile of the reconfigurable fabric.

---
 rtl/pe_pkg.sv | 55 +++++
 rtl/pe_alu.sv | 38 +++
 rtl/pe_6bus.sv | 80 ++++++++
 tb/tb_pe_6bus.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the CGRA processing element: opcodes, source selects,
// configuration field layout and the packed configuration word.
package pe_pkg;

  localparam int DATA_W = 32;
  localparam int CFG_W  = 22;

  // ALU operations
  localparam logic [3:0] OP_PASSA = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_SHL   = 4'd7;
  localparam logic [3:0] OP_SHR   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_SLT   = 4'd10;
  localparam logic [3:0] OP_EQ    = 4'd11;
  localparam logic [3:0] OP_MAX   = 4'd12;
  localparam logic [3:0] OP_MIN   = 4'd13;
  localparam logic [3:0] OP_PASSB = 4'd14;
  localparam logic [3:0] OP_ZERO  = 4'd15;

  // Operand sources; anything from SRC_ZERO upward reads constant 0
  localparam logic [3:0] SRC_UP       = 4'd0;
  localparam logic [3:0] SRC_DOWN     = 4'd1;
  localparam logic [3:0] SRC_LEFT     = 4'd2;
  localparam logic [3:0] SRC_RIGHT    = 4'd3;
  localparam logic [3:0] SRC_BYPASS_1 = 4'd4;
  localparam logic [3:0] SRC_BYPASS_2 = 4'd5;
  localparam logic [3:0] SRC_R        = 4'd6;
  localparam logic [3:0] SRC_Q        = 4'd7;
  localparam logic [3:0] SRC_ZERO     = 4'd8;

  localparam logic [3:0] RSEL_ALU  = 4'd8;
  localparam logic [3:0] RSEL_HOLD = 4'd15;

  localparam int CFG_SRC_A_LSB = 0;
  localparam int CFG_SRC_B_LSB = 4;
  localparam int CFG_OP_LSB    = 8;
  localparam int CFG_RSEL_LSB  = 12;
  localparam int CFG_OEN_LSB   = 16;

  // oen bit order: up, down, left, right, bypass_1, bypass_2
  typedef struct packed {
    logic [5:0] oen;
    logic [3:0] rsel;
    logic [3:0] op;
    logic [3:0] src_b;
    logic [3:0] src_a;
  } pe_cfg_t;

endpackage

// File: rtl/pe_alu.sv
// Combinational 16-operation ALU; all arithmetic wraps modulo 2^WIDTH.
module pe_alu
  import pe_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (op)
      OP_PASSA: result = a;
      OP_ADD:   result = a + b;
      OP_SUB:   result = a - b;
      OP_MUL:   result = a * b;
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_SHL:   result = a << shamt;
      OP_SHR:   result = a >> shamt;
      OP_SRA:   result = $signed(a) >>> shamt;
      OP_SLT:   result[0] = ($signed(a) < $signed(b));
      OP_EQ:    result[0] = (a == b);
      OP_MAX:   result = ($signed(a) > $signed(b)) ? a : b;
      OP_MIN:   result = ($signed(a) < $signed(b)) ? a : b;
      OP_PASSB: result = b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/pe_6bus.sv
// Six-bus CGRA processing element: two operand muxes, ALU, holding register R,
// result register Q and per-bus output gating of Q.
module pe_6bus
  import pe_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CFG_W = pe_pkg::CFG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_up,
  input  logic [WIDTH-1:0] din_down,
  input  logic [WIDTH-1:0] din_left,
  input  logic [WIDTH-1:0] din_right,
  input  logic [WIDTH-1:0] din_bypass_1,
  input  logic [WIDTH-1:0] din_bypass_2,
  input  logic [CFG_W-1:0] configuration,
  output logic [WIDTH-1:0] dout_up,
  output logic [WIDTH-1:0] dout_down,
  output logic [WIDTH-1:0] dout_left,
  output logic [WIDTH-1:0] dout_right,
  output logic [WIDTH-1:0] dout_bypass_1,
  output logic [WIDTH-1:0] dout_bypass_2
);

  pe_cfg_t          cfg;
  logic [WIDTH-1:0] din [6];
  logic [WIDTH-1:0] q, r;
  logic [WIDTH-1:0] op_a, op_b, alu_res;

  assign cfg    = pe_cfg_t'(configuration);
  assign din[0] = din_up;
  assign din[1] = din_down;
  assign din[2] = din_left;
  assign din[3] = din_right;
  assign din[4] = din_bypass_1;
  assign din[5] = din_bypass_2;

  // R and Q read their pre-edge values, which gives feedback/accumulation
  always_comb begin
    op_a = '0;
    if (cfg.src_a < SRC_R)       op_a = din[cfg.src_a[2:0]];
    else if (cfg.src_a == SRC_R) op_a = r;
    else if (cfg.src_a == SRC_Q) op_a = q;
  end

  always_comb begin
    op_b = '0;
    if (cfg.src_b < SRC_R)       op_b = din[cfg.src_b[2:0]];
    else if (cfg.src_b == SRC_R) op_b = r;
    else if (cfg.src_b == SRC_Q) op_b = q;
  end

  pe_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (cfg.op),
    .result (alu_res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
      r <= '0;
    end else begin
      q <= alu_res;
      if (cfg.rsel < 4'd6)          r <= din[cfg.rsel[2:0]];
      else if (cfg.rsel == RSEL_ALU) r <= alu_res;
    end
  end

  // Q is already cleared by reset, so gating alone keeps dout at 0 in reset
  assign dout_up       = cfg.oen[0] ? q : '0;
  assign dout_down     = cfg.oen[1] ? q : '0;
  assign dout_left     = cfg.oen[2] ? q : '0;
  assign dout_right    = cfg.oen[3] ? q : '0;
  assign dout_bypass_1 = cfg.oen[4] ? q : '0;
  assign dout_bypass_2 = cfg.oen[5] ? q : '0;

endmodule

// File: tb/tb_pe_6bus.sv
// Bench for pe_6bus: directed scenarios plus random configurations against an
// arithmetic reference model of the PE.
module tb_pe_6bus;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] din_v [6];
  logic [21:0] cfg_w;
  logic [31:0] dout_v [6];

  int errors = 0;
  int checks = 0;

  // model state
  logic [31:0] m_q = '0;
  logic [31:0] m_r = '0;
  int          c_a, c_b, c_op, c_rs;
  logic [5:0]  c_oen;

  always #5 clk = ~clk;

  pe_6bus dut (
    .clk           (clk),
    .rst           (rst),
    .din_up        (din_v[0]),
    .din_down      (din_v[1]),
    .din_left      (din_v[2]),
    .din_right     (din_v[3]),
    .din_bypass_1  (din_v[4]),
    .din_bypass_2  (din_v[5]),
    .configuration (cfg_w),
    .dout_up       (dout_v[0]),
    .dout_down     (dout_v[1]),
    .dout_left     (dout_v[2]),
    .dout_right    (dout_v[3]),
    .dout_bypass_1 (dout_v[4]),
    .dout_bypass_2 (dout_v[5])
  );

  function automatic logic [31:0] ref_alu(int op, longint unsigned a, longint unsigned b);
    longint unsigned m = 64'h1_0000_0000;
    longint unsigned res;
    longint sa, sb, p, v;
    int sh;
    sh = int'(b % 32);
    p  = longint'(1) << sh;
    sa = (a >= 64'h8000_0000) ? longint'(a) - longint'(m) : longint'(a);
    sb = (b >= 64'h8000_0000) ? longint'(b) - longint'(m) : longint'(b);
    case (op)
      0:  res = a;
      1:  res = (a + b) % m;
      2:  res = (a + m - b) % m;
      3:  res = (a * b) % m;
      4:  res = a & b;
      5:  res = a | b;
      6:  res = a ^ b;
      7:  res = (a * longint'(p)) % m;
      8:  res = a / longint'(p);
      9:  begin
            v = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
            res = (v < 0) ? longint'(m) + v : v;
          end
      10: res = (sa < sb) ? 1 : 0;
      11: res = (a == b) ? 1 : 0;
      12: res = (sa > sb) ? a : b;
      13: res = (sa < sb) ? a : b;
      14: res = b;
      default: res = 0;
    endcase
    return res[31:0];
  endfunction

  function automatic logic [31:0] src_val(int sel);
    if (sel < 6) return din_v[sel];
    if (sel == 6) return m_r;
    if (sel == 7) return m_q;
    return 32'd0;
  endfunction

  task automatic set_cfg(input int a, input int b, input int op, input int rs, input logic [5:0] oe);
    c_a = a; c_b = b; c_op = op; c_rs = rs; c_oen = oe;
    cfg_w = {oe, 4'(rs), 4'(op), 4'(b), 4'(a)};
  endtask

  // Advance one clock edge and move the model to the post-edge state
  task automatic tick();
    logic [31:0] nq, nr;
    nq = ref_alu(c_op, src_val(c_a), src_val(c_b));
    nr = m_r;
    if (c_rs < 6) nr = din_v[c_rs];
    else if (c_rs == 8) nr = nq;
    @(posedge clk);
    #1;
    m_q = nq;
    m_r = nr;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) din_v[i] = $urandom;
    set_cfg(0, 2, 1, 15, 6'h3F);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (dout_v[i] !== 32'd0) begin
        errors++;
        $display("FAIL reset_dout[%0d] got=%h exp=%h", i, dout_v[i], 32'd0);
      end
    end
    m_q = '0; m_r = '0;
    rst = 1'b1;
    set_cfg(0, 8, 0, 15, 6'h3F);
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (dout_v[i] !== din_v[0]) begin
        errors++;
        $display("FAIL reset_release[%0d] got=%h exp=%h", i, dout_v[i], din_v[0]);
      end
    end
  endtask

  task automatic test_mul();
    logic [31:0] exp_v [2];
    exp_v[0] = 32'd140;
    exp_v[1] = 32'd0;
    set_cfg(0, 2, 3, 15, 6'h3F);
    for (int k = 0; k < 2; k++) begin
      din_v[0] = (k == 0) ? 32'd10 : 32'h10000;
      din_v[2] = (k == 0) ? 32'd14 : 32'h10000;
      tick();
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (dout_v[i] !== exp_v[k] || dout_v[i] !== m_q) begin
          errors++;
          $display("FAIL mul%0d[%0d] got=%h exp=%h", k, i, dout_v[i], exp_v[k]);
        end
      end
    end
  endtask

  task automatic test_oen();
    logic [31:0] e;
    din_v[0] = 32'd7;
    set_cfg(0, 8, 0, 15, 6'b000101);
    tick();
    for (int i = 0; i < 6; i++) begin
      e = (i == 0 || i == 2) ? 32'd7 : 32'd0;
      checks++;
      if (dout_v[i] !== e) begin
        errors++;
        $display("FAIL oen_mask[%0d] got=%h exp=%h", i, dout_v[i], e);
      end
    end
    // oen acts combinationally, no edge needed
    set_cfg(0, 8, 0, 15, 6'b111010);
    #1;
    for (int i = 0; i < 6; i++) begin
      e = (i == 0 || i == 2) ? 32'd0 : 32'd7;
      checks++;
      if (dout_v[i] !== e) begin
        errors++;
        $display("FAIL oen_comb[%0d] got=%h exp=%h", i, dout_v[i], e);
      end
    end
  endtask

  task automatic test_accumulate();
    rst = 1'b0;
    #1;
    m_q = '0; m_r = '0;
    rst = 1'b1;
    din_v[4] = 32'd9;
    set_cfg(7, 4, 1, 15, 6'h3F);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (dout_v[0] !== 32'(9 * k) || dout_v[5] !== m_q) begin
        errors++;
        $display("FAIL accum%0d got=%h exp=%h", k, dout_v[0], 32'(9 * k));
      end
    end
    rst = 1'b0;
    #1;
    m_q = '0; m_r = '0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (dout_v[i] !== 32'd0) begin
        errors++;
        $display("FAIL accum_reset[%0d] got=%h exp=%h", i, dout_v[i], 32'd0);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_hold();
    din_v[3] = 32'd8;
    set_cfg(8, 8, 15, 3, 6'h3F);
    tick();
    set_cfg(6, 8, 0, 15, 6'h3F);
    for (int k = 0; k < 3; k++) begin
      din_v[3] = $urandom;
      tick();
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (dout_v[i] !== 32'd8 || m_q !== 32'd8) begin
          errors++;
          $display("FAIL hold%0d[%0d] got=%h exp=%h", k, i, dout_v[i], 32'd8);
        end
      end
    end
  endtask

  task automatic test_signed_ops();
    int          ops [4];
    logic [31:0] av [4], bv [4], ev [4];
    ops[0] = 2;  av[0] = 32'd5;        bv[0] = 32'd6; ev[0] = 32'hFFFFFFFF;
    ops[1] = 10; av[1] = 32'hFFFFFFFF; bv[1] = 32'd1; ev[1] = 32'd1;
    ops[2] = 9;  av[2] = 32'h80000000; bv[2] = 32'd4; ev[2] = 32'hF8000000;
    ops[3] = 13; av[3] = 32'hFFFFFFFD; bv[3] = 32'd2; ev[3] = 32'hFFFFFFFD;
    for (int k = 0; k < 4; k++) begin
      din_v[0] = av[k];
      din_v[1] = bv[k];
      set_cfg(0, 1, ops[k], 15, 6'h3F);
      tick();
      checks++;
      if (dout_v[3] !== ev[k] || m_q !== ev[k]) begin
        errors++;
        $display("FAIL signed_op%0d got=%h exp=%h", ops[k], dout_v[3], ev[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 6; i++)
        din_v[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      set_cfg($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), 6'($urandom_range(0, 63)));
      tick();
      for (int i = 0; i < 6; i++) begin
        e = c_oen[i] ? m_q : 32'd0;
        checks++;
        if (dout_v[i] !== e) begin
          errors++;
          $display("FAIL random%0d op=%0d[%0d] got=%h exp=%h", n, c_op, i, dout_v[i], e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    // R loads from the ALU while the same cycle reads old R
    din_v[0] = 32'd3;
    set_cfg(6, 0, 1, 8, 6'h3F);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (dout_v[1] !== m_q) begin
        errors++;
        $display("FAIL r_feedback%0d got=%h exp=%h", k, dout_v[1], m_q);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) din_v[i] = '0;
    cfg_w = '0;
    test_reset();
    test_mul();
    test_oen();
    test_accumulate();
    test_hold();
    test_signed_ops();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
